ahb_lite_initiator: RTL and testbench

- AHB-Lite bus master: converts a simple valid/ready command stream from a local requester (boot loader, debug bridge, DMA engine) into single NONSEQ AHB-Lite transfers.
- Drives the shared AHB-Lite fabric toward slaves such as the ROM and SRAM controllers.
- Overlaps the next address phase with the current data phase, giving one transfer per cycle when there are no wait states.
- Handles slave wait states and the two-cycle ERROR response. Returns one response per command, in order.

---
 rtl/ahb_lite_initiator.sv | 129 ++++++++++++
 tb/tb_ahb_lite_initiator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_initiator.sv
// AHB-Lite single-transfer initiator: turns a valid/ready command stream into
// pipelined NONSEQ transfers and returns one in-order response per command.
module ahb_lite_initiator #(
   parameter logic [3:0] PROT = 4'b0011
) (
   input  logic        HCLK,
   input  logic        HRESET,
   // local command / response stream
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [1:0]  cmd_size,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   // AHB-Lite master interface
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [1:0]  HRESP,
   input  logic [31:0] HRDATA
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   logic        r_a_valid;
   logic [31:0] r_a_addr;
   logic        r_a_write;
   logic [1:0]  r_a_size;
   logic [31:0] r_a_wdata;

   logic        r_d_valid;
   logic        r_d_write;
   logic [31:0] r_d_wdata;

   logic        r_cancel;

   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;

   logic        w_cmd_ready;
   logic        w_accept;
   logic        w_advance;
   logic        w_complete;
   logic        w_err_first;
   logic        w_unused;

   // Only bit 0 of HRESP carries meaning on AHB-Lite.
   assign w_unused = HRESP[1];

   assign w_cmd_ready = ~HRESET & (~r_a_valid | (HREADY & ~r_cancel));
   assign w_accept    = cmd_valid & w_cmd_ready;
   assign w_advance   = HREADY & r_a_valid & ~r_cancel;
   assign w_complete  = HREADY & r_d_valid;
   // Cycle one of the two-cycle ERROR: the queued address must be withdrawn.
   assign w_err_first = r_d_valid & ~HREADY & HRESP[0];

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_a_valid   <= 1'b0;
         r_a_addr    <= 32'h0;
         r_a_write   <= 1'b0;
         r_a_size    <= 2'b10;
         r_a_wdata   <= 32'h0;
         r_d_valid   <= 1'b0;
         r_d_write   <= 1'b0;
         r_d_wdata   <= 32'h0;
         r_cancel    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a_valid <= 1'b1;
            r_a_addr  <= cmd_addr;
            r_a_write <= cmd_write;
            r_a_size  <= cmd_size;
            r_a_wdata <= cmd_wdata;
         end else if (w_advance) begin
            r_a_valid <= 1'b0;
         end

         if (w_advance) begin
            r_d_valid <= 1'b1;
            r_d_write <= r_a_write;
            r_d_wdata <= r_a_wdata;
         end else if (w_complete) begin
            r_d_valid <= 1'b0;
         end

         r_rsp_valid <= w_complete;
         if (w_complete) begin
            r_rsp_err   <= HRESP[0];
            r_rsp_rdata <= r_d_write ? 32'h0 : HRDATA;
         end

         if (w_complete) begin
            r_cancel <= 1'b0;
         end else if (w_err_first) begin
            r_cancel <= 1'b1;
         end
      end
   end

   assign cmd_ready = w_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

   assign HTRANS    = (r_a_valid & ~r_cancel) ? TRANS_NONSEQ : TRANS_IDLE;
   assign HADDR     = r_a_addr;
   assign HWRITE    = r_a_write;
   assign HSIZE     = {1'b0, r_a_size};
   assign HBURST    = 3'b000;
   assign HPROT     = PROT;
   assign HMASTLOCK = 1'b0;
   assign HWDATA    = r_d_wdata;

endmodule

// File: tb/tb_ahb_lite_initiator.sv
// Directed bench for ahb_lite_initiator: bus-phase checks inline, responses
// checked by a scoreboard monitor against a queue of expected results.
module tb_ahb_lite_initiator;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [1:0]  HRESP;
   logic [31:0] HRDATA;

   int checks   = 0;
   int failures = 0;
   logic [32:0] exp_q[$];   // {err, rdata}

   always #5 HCLK = ~HCLK;

   ahb_lite_initiator #(.PROT(4'b0011)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every response pulse must match the oldest expectation.
   always @(negedge HCLK) begin
      if (rsp_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected actual rdata=0x%08h err=%0b expected=none", rsp_rdata, rsp_err);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if ({rsp_err, rsp_rdata} !== e) begin
               failures++;
               $display("FAIL rsp_data actual err=%0b rdata=0x%08h expected err=%0b rdata=0x%08h",
                        rsp_err, rsp_rdata, e[32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
   endtask

   task automatic idle_cmd();
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 2'b00; cmd_wdata = 32'h0;
   endtask

   initial begin
      HRESET = 1'b1; HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
      idle_cmd();
      tick(); tick();
      @(negedge HCLK);
      chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hsize", {29'h0, HSIZE}, 32'h2);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
      tick();
      HRESET = 1'b0;
      tick();

      // single read
      issue(1'b0, 32'h100, 2'd2, 32'h0);
      @(negedge HCLK); chk("rd_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      tick(); exp_q.push_back({1'b0, 32'hDEADBEEF});
      idle_cmd();
      @(negedge HCLK);
      chk("rd_htrans", {30'h0, HTRANS}, 32'h2);
      chk("rd_haddr", HADDR, 32'h100);
      chk("rd_hwrite", {31'h0, HWRITE}, 32'h0);
      chk("rd_hsize", {29'h0, HSIZE}, 32'h2);
      tick();
      HRDATA = 32'hDEADBEEF;
      tick();
      HRDATA = 32'h0;
      @(negedge HCLK); chk("rd_rsp_cycle3", {31'h0, rsp_valid}, 32'h1);
      tick(); tick();

      // back-to-back writes
      issue(1'b1, 32'h200, 2'd2, 32'h11111111);
      tick(); exp_q.push_back({1'b0, 32'h0});
      issue(1'b1, 32'h204, 2'd2, 32'h22222222);
      @(negedge HCLK);
      chk("b2b_htrans1", {30'h0, HTRANS}, 32'h2);
      chk("b2b_haddr1", HADDR, 32'h200);
      chk("b2b_hwrite1", {31'h0, HWRITE}, 32'h1);
      chk("b2b_ready1", {31'h0, cmd_ready}, 32'h1);
      tick(); exp_q.push_back({1'b0, 32'h0});
      idle_cmd();
      @(negedge HCLK);
      chk("b2b_htrans2", {30'h0, HTRANS}, 32'h2);
      chk("b2b_haddr2", HADDR, 32'h204);
      chk("b2b_hwdata1", HWDATA, 32'h11111111);
      tick();
      @(negedge HCLK);
      chk("b2b_hwdata2", HWDATA, 32'h22222222);
      chk("b2b_rsp3", {31'h0, rsp_valid}, 32'h1);
      chk("b2b_idle3", {30'h0, HTRANS}, 32'h0);
      tick();
      @(negedge HCLK); chk("b2b_rsp4", {31'h0, rsp_valid}, 32'h1);
      tick(); tick();

      // wait states
      issue(1'b0, 32'h300, 2'd2, 32'h0);
      tick(); exp_q.push_back({1'b0, 32'h33330000});
      issue(1'b0, 32'h304, 2'd2, 32'h0);
      tick(); exp_q.push_back({1'b0, 32'h44440000});
      idle_cmd();
      HREADY = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge HCLK);
         chk("ws_htrans", {30'h0, HTRANS}, 32'h2);
         chk("ws_haddr", HADDR, 32'h304);
         chk("ws_ready", {31'h0, cmd_ready}, 32'h0);
         chk("ws_rsp", {31'h0, rsp_valid}, 32'h0);
         tick();
      end
      HREADY = 1'b1; HRDATA = 32'h33330000;
      @(negedge HCLK); chk("ws_ready_rel", {31'h0, cmd_ready}, 32'h1);
      tick();
      HRDATA = 32'h44440000;
      @(negedge HCLK);
      chk("ws_rsp1", {31'h0, rsp_valid}, 32'h1);
      chk("ws_idle", {30'h0, HTRANS}, 32'h0);
      tick();
      HRDATA = 32'h0;
      @(negedge HCLK); chk("ws_rsp2", {31'h0, rsp_valid}, 32'h1);
      tick(); tick();

      // error with a pending address
      issue(1'b1, 32'h400, 2'd2, 32'h00000055);
      tick(); exp_q.push_back({1'b1, 32'h0});
      issue(1'b0, 32'h404, 2'd2, 32'h0);
      tick(); exp_q.push_back({1'b0, 32'h66660000});
      idle_cmd();
      HREADY = 1'b0; HRESP = 2'b01;
      @(negedge HCLK);
      chk("err1_htrans", {30'h0, HTRANS}, 32'h2);
      chk("err1_hwdata", HWDATA, 32'h55);
      tick();
      HREADY = 1'b1;
      @(negedge HCLK);
      chk("err2_htrans_idle", {30'h0, HTRANS}, 32'h0);
      chk("err2_haddr", HADDR, 32'h404);
      chk("err2_ready", {31'h0, cmd_ready}, 32'h0);
      tick();
      HRESP = 2'b00;
      @(negedge HCLK);
      chk("err_reissue_htrans", {30'h0, HTRANS}, 32'h2);
      chk("err_reissue_haddr", HADDR, 32'h404);
      chk("err_reissue_hwrite", {31'h0, HWRITE}, 32'h0);
      chk("err_rsp1", {31'h0, rsp_valid}, 32'h1);
      tick();
      HRDATA = 32'h66660000;
      tick();
      HRDATA = 32'h0;
      @(negedge HCLK); chk("err_rsp2", {31'h0, rsp_valid}, 32'h1);
      tick(); tick();

      // reset in the middle of a wait-stated data phase
      issue(1'b0, 32'h600, 2'd2, 32'h0);
      tick();
      idle_cmd();
      tick();
      HREADY = 1'b0; HRESET = 1'b1;
      @(negedge HCLK); chk("mrst_ready", {31'h0, cmd_ready}, 32'h0);
      tick();
      HRESET = 1'b0; HREADY = 1'b1;
      @(negedge HCLK);
      chk("mrst_idle", {30'h0, HTRANS}, 32'h0);
      chk("mrst_rsp", {31'h0, rsp_valid}, 32'h0);
      chk("mrst_ready_rel", {31'h0, cmd_ready}, 32'h1);
      tick();
      @(negedge HCLK); chk("mrst_rsp2", {31'h0, rsp_valid}, 32'h0);
      issue(1'b0, 32'h500, 2'd2, 32'h0);
      tick(); exp_q.push_back({1'b0, 32'h50505050});
      idle_cmd();
      @(negedge HCLK); chk("mrst_haddr", HADDR, 32'h500);
      tick();
      HRDATA = 32'h50505050;
      tick();
      HRDATA = 32'h0;
      @(negedge HCLK); chk("mrst_rsp_new", {31'h0, rsp_valid}, 32'h1);
      tick(); tick();

      // byte write
      issue(1'b1, 32'h3, 2'd0, 32'h000000A5);
      tick(); exp_q.push_back({1'b0, 32'h0});
      idle_cmd();
      @(negedge HCLK);
      chk("bw_hsize", {29'h0, HSIZE}, 32'h0);
      chk("bw_haddr", HADDR, 32'h3);
      chk("bw_hburst", {29'h0, HBURST}, 32'h0);
      chk("bw_hprot", {28'h0, HPROT}, 32'h3);
      chk("bw_hmastlock", {31'h0, HMASTLOCK}, 32'h0);
      chk("bw_htrans", {30'h0, HTRANS}, 32'h2);
      tick();
      @(negedge HCLK); chk("bw_hwdata", HWDATA, 32'hA5);
      tick();
      @(negedge HCLK); chk("bw_rsp", {31'h0, rsp_valid}, 32'h1);
      tick(); tick(); tick();

      @(negedge HCLK);
      chk("sb_drained", exp_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
